// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU has priority, loader/debug port is served when the CPU is idle.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cpu_mem_cmd,
    input  logic [8:0]  cpu_mem_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_wait,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [8:0]  ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_gnt,
    output logic        ldr_rvalid,
    output logic [15:0] ldr_rdata,
    output logic [7:0]  ram_addr,
    output logic        ram_write,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b11;

    state_t      state_r;
    logic        io_r;
    logic        rvalid_r;
    logic [15:0] rdata_r;
    logic        wait_r;
`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0]  starve_cnt_r;
`endif

    logic        cpu_cmd_s;
    logic        cpu_active_s;
    logic        gnt_s;
    logic [7:0]  ram_addr_s;
    logic [15:0] ram_din_s;
    logic        ram_write_s;

    // Address bit 8 selects I/O space, which never reaches the RAM array.
    function automatic logic ram_wr_ok(input logic is_write, input logic addr_hi);
        return is_write & ~addr_hi;
    endfunction

    // Decode whether the CPU owns the RAM this cycle and whether the loader is granted.
    always_comb begin
        cpu_cmd_s    = (cpu_mem_cmd == CMD_WRITE) || (cpu_mem_cmd == CMD_READ);
        cpu_active_s = cpu_cmd_s && !wait_r;
        gnt_s        = !reset && ldr_req && (state_r == IDLE) && !cpu_active_s;
    end

    // RAM port steering; CPU path is combinational so it sees no added latency.
    always_comb begin
        ram_addr_s  = cpu_mem_addr[7:0];
        ram_din_s   = cpu_wdata;
        ram_write_s = 1'b0;
        if (reset) begin
            ram_write_s = 1'b0;
        end else if (gnt_s) begin
            ram_addr_s  = ldr_addr[7:0];
            ram_din_s   = ldr_wdata;
            ram_write_s = ram_wr_ok(ldr_we, ldr_addr[8]);
        end else if (cpu_active_s) begin
            ram_write_s = ram_wr_ok(cpu_mem_cmd == CMD_WRITE, cpu_mem_addr[8]);
        end else begin
            ram_write_s = 1'b0;
        end
    end

    // Loader read sequencing, read-data capture and starvation tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            io_r     <= 1'b0;
            rvalid_r <= 1'b0;
            rdata_r  <= 16'h0000;
            wait_r   <= 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt_r <= 3'd0;
`endif
        end else begin
            rvalid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (gnt_s && !ldr_we) begin
                        state_r <= RD_WAIT;
                        io_r    <= ldr_addr[8];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    rdata_r  <= io_r ? 16'h0000 : ram_dout;
                    rvalid_r <= 1'b1;
                    state_r  <= RD_CAP;
                end
                RD_CAP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
`ifdef MEM_ARB_STARVE_GUARD_EN
            // A blocked request at saturation forces a one-cycle CPU stall next cycle.
            wait_r <= (starve_cnt_r == 3'd7) && ldr_req && !gnt_s && (state_r == IDLE);
            if (!ldr_req || gnt_s) begin
                starve_cnt_r <= 3'd0;
            end else if (state_r == IDLE) begin
                starve_cnt_r <= (starve_cnt_r == 3'd7) ? 3'd7 : starve_cnt_r + 3'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
`else
            wait_r <= 1'b0;
`endif
        end
    end

    assign cpu_rdata  = ram_dout;
    assign cpu_wait   = wait_r;
    assign ldr_gnt    = gnt_s;
    assign ldr_rvalid = rvalid_r;
    assign ldr_rdata  = rdata_r;
    assign ram_addr   = ram_addr_s;
    assign ram_write  = ram_write_s;
    assign ram_din    = ram_din_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous-read RAM.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  cpu_mem_cmd;
    logic [8:0]  cpu_mem_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_wait;
    logic        ldr_req;
    logic        ldr_we;
    logic [8:0]  ldr_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [15:0] ldr_rdata;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    logic [15:0] mem [256];

    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_mem_cmd(cpu_mem_cmd), .cpu_mem_addr(cpu_mem_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // move to the sampling point mid-cycle
    task automatic settle();
        #4;
    endtask

    initial begin
        reset = 1'b1; cpu_mem_cmd = 2'b00; cpu_mem_addr = 9'h000; cpu_wdata = 16'h0000;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 9'h005; ldr_wdata = 16'hBEEF;
        tick();
        settle();
        chk("rst_gnt", {15'd0, ldr_gnt}, 16'd0);
        chk("rst_ram_write", {15'd0, ram_write}, 16'd0);
        chk("rst_cpu_wait", {15'd0, cpu_wait}, 16'd0);
        chk("rst_rvalid", {15'd0, ldr_rvalid}, 16'd0);
        chk("rst_rdata", ldr_rdata, 16'h0000);

        // loader write with idle CPU
        tick(); reset = 1'b0; cpu_mem_addr = 9'h033;
        settle();
        chk("lw_gnt", {15'd0, ldr_gnt}, 16'd1);
        chk("lw_ram_write", {15'd0, ram_write}, 16'd1);
        chk("lw_ram_addr", {8'd0, ram_addr}, 16'h0005);
        chk("lw_ram_din", ram_din, 16'hBEEF);

        tick(); ldr_req = 1'b0;
        settle();
        chk("idle_gnt", {15'd0, ldr_gnt}, 16'd0);
        chk("idle_ram_write", {15'd0, ram_write}, 16'd0);
        chk("idle_ram_addr", {8'd0, ram_addr}, 16'h0033);

        // loader read of 005, with a pending write that must wait for IDLE
        tick(); ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'h005;
        settle();
        chk("lr_gnt", {15'd0, ldr_gnt}, 16'd1);
        chk("lr_ram_write", {15'd0, ram_write}, 16'd0);
        chk("lr_ram_addr", {8'd0, ram_addr}, 16'h0005);
        tick(); ldr_we = 1'b1; ldr_addr = 9'h010; ldr_wdata = 16'h1234;
        settle();
        chk("rdwait_gnt", {15'd0, ldr_gnt}, 16'd0);
        chk("rdwait_rvalid", {15'd0, ldr_rvalid}, 16'd0);
        tick();
        settle();
        chk("rdcap_gnt", {15'd0, ldr_gnt}, 16'd0);
        chk("rdcap_rvalid", {15'd0, ldr_rvalid}, 16'd1);
        chk("rdcap_rdata", ldr_rdata, 16'hBEEF);
        tick();
        settle();
        chk("lw2_gnt", {15'd0, ldr_gnt}, 16'd1);
        chk("lw2_rvalid", {15'd0, ldr_rvalid}, 16'd0);
        chk("lw2_ram_write", {15'd0, ram_write}, 16'd1);

        // CPU writes: I/O space then RAM space
        tick(); ldr_req = 1'b0; cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h140; cpu_wdata = 16'hAAAA;
        settle();
        chk("cw_io_ram_write", {15'd0, ram_write}, 16'd0);
        chk("cw_io_ram_addr", {8'd0, ram_addr}, 16'h0040);
        tick(); cpu_mem_addr = 9'h006; cpu_wdata = 16'h5555;
        settle();
        chk("cw_ram_write", {15'd0, ram_write}, 16'd1);
        chk("cw_ram_din", ram_din, 16'h5555);
        tick(); cpu_mem_cmd = 2'b11;
        settle();
        chk("cr_ram_write", {15'd0, ram_write}, 16'd0);
        tick(); cpu_mem_cmd = 2'b10; cpu_mem_addr = 9'h044;
        settle();
        chk("cr_rdata", cpu_rdata, 16'h5555);
        chk("cmd10_ram_write", {15'd0, ram_write}, 16'd0);

        // loader read of I/O space while CPU reads in RD_WAIT
        tick(); cpu_mem_cmd = 2'b00; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'h1FF;
        settle();
        chk("lrio_gnt", {15'd0, ldr_gnt}, 16'd1);
        tick(); ldr_req = 1'b0; cpu_mem_cmd = 2'b11; cpu_mem_addr = 9'h010;
        settle();
        chk("lrio_wait_ram_addr", {8'd0, ram_addr}, 16'h0010);
        tick(); cpu_mem_cmd = 2'b00;
        settle();
        chk("lrio_rvalid", {15'd0, ldr_rvalid}, 16'd1);
        chk("lrio_rdata", ldr_rdata, 16'h0000);
        chk("lrio_cpu_rdata", cpu_rdata, 16'h1234);

        // loader read of RAM while CPU reads another word in RD_WAIT
        tick(); ldr_req = 1'b1; ldr_addr = 9'h005;
        settle();
        chk("lr2_gnt", {15'd0, ldr_gnt}, 16'd1);
        tick(); ldr_req = 1'b0; cpu_mem_cmd = 2'b11; cpu_mem_addr = 9'h006;
        settle();
        chk("lr2_wait_ram_addr", {8'd0, ram_addr}, 16'h0006);
        tick(); cpu_mem_cmd = 2'b00;
        settle();
        chk("lr2_rvalid", {15'd0, ldr_rvalid}, 16'd1);
        chk("lr2_rdata", ldr_rdata, 16'hBEEF);
        chk("lr2_cpu_rdata", cpu_rdata, 16'h5555);

        // reset while a loader read sits in RD_WAIT
        tick(); ldr_req = 1'b1; ldr_addr = 9'h006;
        settle();
        chk("lr3_gnt", {15'd0, ldr_gnt}, 16'd1);
        tick(); ldr_req = 1'b0; reset = 1'b1; cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h007;
        settle();
        chk("rstmid_ram_write", {15'd0, ram_write}, 16'd0);
        tick(); reset = 1'b0; cpu_mem_cmd = 2'b00;
        settle();
        chk("rstmid_rvalid", {15'd0, ldr_rvalid}, 16'd0);
        chk("rstmid_rdata", ldr_rdata, 16'h0000);
        chk("rstmid_cpu_wait", {15'd0, cpu_wait}, 16'd0);
        chk("rstmid_gnt", {15'd0, ldr_gnt}, 16'd0);
        tick();
        settle();
        chk("rstmid_rvalid2", {15'd0, ldr_rvalid}, 16'd0);

        // CPU READ held every cycle while the loader requests
        cpu_mem_cmd = 2'b11; ldr_we = 1'b1; ldr_addr = 9'h020; ldr_wdata = 16'h7777;
        for (int k = 1; k <= 12; k++) begin
            tick();
            ldr_req = !(GUARD && k > 9);
            cpu_mem_addr = 9'(k);
            settle();
            chk($sformatf("starve_gnt_%0d", k), {15'd0, ldr_gnt}, {15'd0, GUARD && k == 9});
            chk($sformatf("starve_wait_%0d", k), {15'd0, cpu_wait}, {15'd0, GUARD && k == 9});
            chk($sformatf("starve_addr_%0d", k), {8'd0, ram_addr},
                (GUARD && k == 9) ? 16'h0020 : 16'(k));
            chk($sformatf("starve_we_%0d", k), {15'd0, ram_write}, {15'd0, GUARD && k == 9});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mem_cmd  in  2  CPU command: 00 NONE, 01 WRITE, 11 READ; 10 treated as NONE.
- cpu_mem_addr  in  9  CPU word address.
- cpu_wdata  in  16  CPU store data.
- cpu_rdata  out  16  RAM read data to CPU; combinational pass of ram_dout.
- cpu_wait  out  1  CPU must hold its current command this cycle.
- ldr_req  in  1  loader/debug port request; held until ldr_gnt.
- ldr_we  in  1  1 write, 0 read; stable while ldr_req high.
- ldr_addr  in  9  loader word address; stable while ldr_req high.
- ldr_wdata  in  16  loader write data; stable while ldr_req high.
- ldr_gnt  out  1  one-cycle pulse: loader access issued to RAM this cycle.
- ldr_rvalid  out  1  one-cycle pulse: ldr_rdata holds read result.
- ldr_rdata  out  16  registered loader read data.
- ram_addr  out  8  RAM word address (selected address bits 7:0).
- ram_write  out  1  RAM write enable.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data, valid one cycle after address (synchronous read).

Function
REQ-002 SHALL use states IDLE, RD_WAIT, RD_CAP.
REQ-003 SHALL give the CPU priority: any cycle with cpu_mem_cmd READ or WRITE and cpu_wait=0 drives ram_addr/ram_din from CPU, zero added latency.
REQ-004 SHALL assert ram_write only for a WRITE whose selected address bit 8 is 0; bit 8 = 1 is I/O space, never written to RAM.
REQ-005 SHALL grant the loader (ldr_gnt=1, RAM driven from loader port) in a cycle when ldr_req=1, state is IDLE, and the CPU is not using RAM.
REQ-006 SHALL, on a loader write grant, remain in IDLE; a further loader grant is allowed the next cycle.
REQ-007 SHALL, on a loader read grant at cycle T, go to RD_WAIT; in T+1 (RD_WAIT -> RD_CAP) register ldr_rdata <= ram_dout, or 16'h0000 if ldr_addr[8]=1; in T+2 (RD_CAP -> IDLE) pulse ldr_rvalid.
REQ-008 SHALL not grant the loader while in RD_WAIT or RD_CAP; CPU accesses in those cycles proceed per REQ-003.
REQ-009 SHALL drive ram_addr/ram_din from the CPU port and ram_write=0 when neither requester is active.
REQ-010 SHALL treat a loader request simultaneous with a CPU access as pending, with no ldr_gnt, per REQ-003.
REQ-011 SHALL keep cpu_wait=0 whenever MEM_ARB_STARVE_GUARD_EN is undefined.

Reset
REQ-012 SHALL, when reset is sampled high, set state IDLE, ldr_gnt=0, ldr_rvalid=0, ldr_rdata=16'h0000, cpu_wait=0, starvation counter=0.
REQ-013 SHALL abandon a loader read in flight when reset occurs mid-operation; no ldr_rvalid is produced for it.
REQ-014 SHALL drive ram_write=0 during any cycle with reset high.

Configuration
REQ-015 SHALL implement the starvation guard only when macro MEM_ARB_STARVE_GUARD_EN is defined.
REQ-016 With MEM_ARB_STARVE_GUARD_EN defined:
- a 3-bit counter increments each cycle ldr_req=1 in IDLE without ldr_gnt, saturating at 7, clearing on ldr_gnt or ldr_req=0.
- when the counter is 7 and the loader is again blocked by the CPU, the next cycle asserts cpu_wait=1, grants the loader, and suppresses the CPU access (ram_write from CPU forced 0).
REQ-017 Without MEM_ARB_STARVE_GUARD_EN: strict CPU priority; counter logic absent; loader may starve indefinitely.

Verification
REQ-018 Bench SHALL cover:
- Idle CPU, loader write addr 9'h005 data 16'hBEEF -> ldr_gnt same cycle, ram_write=1, ram_addr=8'h05; a loader read of 9'h005 later -> ldr_rvalid 2 cycles after gnt, ldr_rdata=16'hBEEF.
- CPU READ held every cycle while ldr_req=1 -> no ldr_gnt, CPU addresses reach RAM unchanged (guard undefined).
- Same as previous with guard defined -> cpu_wait=1 and ldr_gnt in the 9th cycle of ldr_req, then cpu_wait returns 0.
- CPU WRITE to 9'h140 -> ram_write=0; loader read of 9'h1FF -> ldr_rdata=16'h0000.
- Reset asserted in RD_WAIT -> no ldr_rvalid, all outputs at reset values next cycle.
- CPU READ in the RD_WAIT cycle of a loader read -> CPU served, loader still receives its own captured data.
